// File: rtl/alu_nibble_seq_pkg.sv
// Shared definitions for the nibble-serial 74S181-style ALU.
// Holds the named function selects and the sequencer state encoding.
// Imported by the nibble slice and the top-level sequencer.
package alu_nibble_seq_pkg;

  // Common 74S181 function selects (S3..S0)
  localparam logic [3:0] ALU_ADD   = 4'b1001;  // m=0: A plus B plus cin
  localparam logic [3:0] ALU_SUB   = 4'b0110;  // m=0: A + ~B + cin (subtract with cin=1)
  localparam logic [3:0] ALU_NOT_A = 4'b0000;  // m=1: ~A
  localparam logic [3:0] ALU_XNOR  = 4'b1001;  // m=1: ~(A ^ B)

  // Sequencer states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_nibble_seq_alu_nibble.sv
// Combinational 4-bit 74S181-style slice with group propagate/generate.
// Latency: purely combinational, no state.
// No handshake; the sequencer feeds it one nibble per clock.
module alu_nibble
  import alu_nibble_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c,
  output logic [3:0] f,
  output logic       c4,
  output logic       c3,
  output logic       p,
  output logic       g
);

  logic [3:0] t;
  logic [3:0] u;
  logic [3:0] h;
  logic [4:0] cc;

  // Per-bit propagate/generate terms, ripple carry and function output.
  // The carry chain runs in logic mode too; the sequencer masks its effects.
  always_comb begin
    t     = '0;
    u     = '0;
    h     = '0;
    f     = '0;
    cc    = '0;
    cc[0] = c;
    for (int i = 0; i < 4; i++) begin
      t[i]    = a[i] | (b[i] & s[0]) | (~b[i] & s[1]);
      u[i]    = (a[i] & ~b[i] & s[2]) | (a[i] & b[i] & s[3]);
      h[i]    = t[i] & ~u[i];
      cc[i+1] = u[i] | (t[i] & cc[i]);
      f[i]    = m ? ~h[i] : (h[i] ^ cc[i]);
    end
  end

  assign c4 = cc[4];
  assign c3 = cc[3];
  assign p  = &t;
  assign g  = u[3] | (t[3] & u[2]) | (t[3] & t[2] & u[1]) | (t[3] & t[2] & t[1] & u[0]);

endmodule

// File: rtl/alu_nibble_seq.sv
// Nibble-serial WIDTH-bit 74S181-style ALU, carry rippled through a register.
// Latency: done pulses N = WIDTH/4 edges after the accepting edge (N+1 cycles incl. start).
// No backpressure: start is only sampled while idle; start while busy is dropped.
module alu_nibble_seq
  import alu_nibble_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         s,
  input  logic               m,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               cout,
  output logic               ovf,
  output logic               zero,
  output logic [WIDTH/4-1:0] grp_p,
  output logic [WIDTH/4-1:0] grp_g
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t          state;
  state_t          state_nxt;

  // Working registers; the visible outputs are only committed on the last
  // nibble so they hold their previous values for the whole run.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [N-1:0]     p_sh;
  logic [N-1:0]     g_sh;
  logic [3:0]       s_q;
  logic             m_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  logic [3:0]       nib_f;
  logic             nib_c4;
  logic             nib_c3;
  logic             nib_p;
  logic             nib_g;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] res_next;
  logic [N-1:0]     p_next;
  logic [N-1:0]     g_next;

  alu_nibble u_nib (
    .a  (a_sh[3:0]),
    .b  (b_sh[3:0]),
    .s  (s_q),
    .m  (m_q),
    .c  (carry_q),
    .f  (nib_f),
    .c4 (nib_c4),
    .c3 (nib_c3),
    .p  (nib_p),
    .g  (nib_g)
  );

  assign accept   = (state == ST_IDLE) && start;
  assign last     = (state == ST_RUN) && (cnt == CW'(N - 1));
  assign busy     = (state == ST_RUN);
  assign res_next = {nib_f, res_sh[WIDTH-1:4]};

  // Group terms including the nibble being computed this cycle.
  always_comb begin
    p_next      = p_sh;
    g_next      = g_sh;
    p_next[cnt] = nib_p;
    g_next[cnt] = nib_g;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: idle until start, then run exactly N nibbles.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_IDLE;
      default:            state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch, nibble shifting, carry ripple and result commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      p_sh    <= '0;
      g_sh    <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      grp_p   <= '0;
      grp_g   <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sh    <= a;
        b_sh    <= b;
        s_q     <= s;
        m_q     <= m;
        carry_q <= cin;
        cnt     <= '0;
        res_sh  <= '0;
        p_sh    <= '0;
        g_sh    <= '0;
      end else if (state == ST_RUN) begin
        a_sh    <= a_sh >> 4;
        b_sh    <= b_sh >> 4;
        res_sh  <= res_next;
        p_sh    <= p_next;
        g_sh    <= g_next;
        carry_q <= nib_c4;
        cnt     <= cnt + CW'(1);
        if (last) begin
          done   <= 1'b1;
          result <= res_next;
          grp_p  <= p_next;
          grp_g  <= g_next;
          zero   <= (res_next == '0);
          // Carry-derived flags only mean something in arithmetic mode.
          cout   <= ~m_q & nib_c4;
          ovf    <= ~m_q & (nib_c3 ^ nib_c4);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq with hand-computed expected values.
// Covers add/sub/logic modes, group P/G, overflow, ignored start and abort by reset.
// Every wait on the DUT is bounded by a cycle budget.
module tb_alu_nibble_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  s;
  logic        m;
  logic        cin;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic [7:0]  grp_p;
  logic [7:0]  grp_g;

  int n_chk  = 0;
  int n_pass = 0;

  alu_nibble_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .s       (s),
    .m       (m),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .cout    (cout),
    .ovf     (ovf),
    .zero    (zero),
    .grp_p   (grp_p),
    .grp_g   (grp_g)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issue one operation and wait (bounded) for done; latency counts the accepting edge.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [3:0] is,
                        input logic im, input logic ic, input string tag);
    int lat;
    @(negedge clk);
    a = ia; b = ib; s = is; m = im; cin = ic; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    chk({tag, "_busy"}, busy, 1'b1);
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 9);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
  endtask

  // Confirm done is a single-cycle pulse.
  task automatic chk_pulse(input string tag);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int dones;
    reset_n = 1'b0;
    start = 1'b0; a = '0; b = '0; s = '0; m = 1'b0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 32'h0);
    chk("rst_busy",   busy,   1'b0);
    chk("rst_done",   done,   1'b0);
    chk("rst_flags",  {cout, ovf, zero}, 3'b000);
    chk("rst_grp",    {grp_p, grp_g}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;

    // 0xFFFFFFFF + 1 wraps to zero with carry out
    run_op(32'hFFFF_FFFF, 32'h1, 4'b1001, 1'b0, 1'b0, "add_wrap");
    chk("add_wrap_res",  result, 32'h0);
    chk("add_wrap_cout", cout, 1'b1);
    chk("add_wrap_ovf",  ovf, 1'b0);
    chk("add_wrap_zero", zero, 1'b1);
    chk("add_wrap_gp",   grp_p, 8'hFF);
    chk("add_wrap_gg",   grp_g, 8'h01);
    chk_pulse("add_wrap");

    // 5 - 7 = -2, borrow shows as cout=0
    run_op(32'd5, 32'd7, 4'b0110, 1'b0, 1'b1, "sub");
    chk("sub_res",  result, 32'hFFFF_FFFE);
    chk("sub_cout", cout, 1'b0);
    chk("sub_ovf",  ovf, 1'b0);
    chk("sub_zero", zero, 1'b0);
    chk("sub_gp",   grp_p, 8'hFE);
    chk("sub_gg",   grp_g, 8'h00);

    // XNOR in logic mode; internal carries exist but cout must be masked
    run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b1001, 1'b1, 1'b0, "xnor");
    chk("xnor_res",  result, 32'hF00F_F00F);
    chk("xnor_cout", cout, 1'b0);
    chk("xnor_ovf",  ovf, 1'b0);
    chk("xnor_gp",   grp_p, 8'hEE);
    chk("xnor_gg",   grp_g, 8'h88);

    // Carry out of nibble 0 into nibble 1
    run_op(32'h0000_000F, 32'h1, 4'b1001, 1'b0, 1'b0, "nib_carry");
    chk("nib_carry_res", result, 32'h10);
    chk("nib_carry_gp",  grp_p, 8'h01);
    chk("nib_carry_gg",  grp_g, 8'h01);

    // Signed overflow into the sign bit
    run_op(32'h7FFF_FFFF, 32'h1, 4'b1001, 1'b0, 1'b0, "ovf");
    chk("ovf_res",  result, 32'h8000_0000);
    chk("ovf_ovf",  ovf, 1'b1);
    chk("ovf_cout", cout, 1'b0);
    chk("ovf_gp",   grp_p, 8'h7F);
    chk("ovf_gg",   grp_g, 8'h01);

    // Start pulsed mid-run must be ignored: 5 + 7 = 12, and no second op follows
    @(negedge clk);
    a = 32'd5; b = 32'd7; s = 4'b1001; m = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 32'h100; b = 32'h100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        chk("midstart_res", result, 32'hC);
      end
    end
    chk("midstart_dones", dones, 1);
    chk("midstart_busy", busy, 1'b0);

    // Reset at cycle 4 of a run aborts it
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1111_1111; s = 4'b1001; m = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_busy",   busy, 1'b0);
    chk("abort_done",   done, 1'b0);
    chk("abort_result", result, 32'h0);
    chk("abort_flags",  {cout, ovf, zero}, 3'b000);
    chk("abort_grp",    {grp_p, grp_g}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);

    // NOT A in logic mode after recovery
    run_op(32'h0F0F_0F0F, 32'h0, 4'b0000, 1'b1, 1'b0, "nota");
    chk("nota_res",  result, 32'hF0F0_F0F0);
    chk("nota_cout", cout, 1'b0);
    chk("nota_gp",   grp_p, 8'h55);
    chk("nota_gg",   grp_g, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
